// File: rtl/io_hub_pkg.sv
// Shared constants for the MCU I/O port hub: IRQ register offsets and default base port IDs.
package io_hub_pkg;

  localparam int IRQ_OFS_MASK = 0;
  localparam int IRQ_OFS_PEND = 1;
  localparam int IRQ_OFS_PRIO = 2;

  localparam int DEF_IN_BASE  = 'h20;
  localparam int DEF_OUT_BASE = 'h40;
  localparam int DEF_IRQ_BASE = 'hF0;

  localparam int MAX_IN     = 16;
  localparam int MAX_OUT    = 16;
  localparam int MAX_IRQ    = 8;
  localparam int PRIO_IDX_W = 3;

endpackage

// File: rtl/irq_edge_latch.sv
// One interrupt source: 2-flop synchroniser, rising-edge detector and sticky W1C pending bit.
module irq_edge_latch (
  input  logic CLK,
  input  logic RESET_N,
  input  logic src,
  input  logic clr,
  output logic pend
);

  logic sync_p0, sync_p1, edge_p2;
  logic vld_p0, vld_p1;
  logic armed;
  logic rise;

  // armed only after a genuine synchronised low, so a source already high at reset release never fires
  assign rise = sync_p1 & ~edge_p2 & armed;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      edge_p2 <= 1'b0;
      vld_p0  <= 1'b0;
      vld_p1  <= 1'b0;
      armed   <= 1'b0;
      pend    <= 1'b0;
    end else begin
      sync_p0 <= src;
      sync_p1 <= sync_p0;
      edge_p2 <= sync_p1;
      vld_p0  <= 1'b1;
      vld_p1  <= vld_p0;
      armed   <= armed | (vld_p1 & ~sync_p1);
      // a set on the same edge as a clear wins
      pend    <= rise | (pend & ~clr);
    end
  end

endmodule

// File: rtl/io_port_hub.sv
// MCU port hub: combinational read mux over input ports and IRQ registers, strobed output
// registers with write pulses, and a masked, prioritised interrupt controller.
module io_port_hub
  import io_hub_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_IN   = 4,
  parameter int NUM_OUT  = 4,
  parameter int NUM_IRQ  = 4,
  parameter int IN_BASE  = DEF_IN_BASE,
  parameter int OUT_BASE = DEF_OUT_BASE,
  parameter int IRQ_BASE = DEF_IRQ_BASE
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic [DATA_W-1:0]          PORT_ID,
  input  logic [DATA_W-1:0]          OUT_PORT,
  input  logic                       IO_STRB,
  input  logic [NUM_IN*DATA_W-1:0]   IN_DATA,
  input  logic [NUM_IRQ-1:0]         IRQ_SRC,
  output logic [DATA_W-1:0]          IN_PORT,
  output logic [NUM_OUT*DATA_W-1:0]  OUT_DATA,
  output logic [NUM_OUT-1:0]         OUT_WSTB,
  output logic                       INTERRUPT
);

  if (NUM_IN < 1 || NUM_IN > MAX_IN) begin : g_bad_num_in
    $error("io_port_hub: NUM_IN must be 1..16");
  end
  if (NUM_OUT < 1 || NUM_OUT > MAX_OUT) begin : g_bad_num_out
    $error("io_port_hub: NUM_OUT must be 1..16");
  end
  if (NUM_IRQ < 1 || NUM_IRQ > MAX_IRQ) begin : g_bad_num_irq
    $error("io_port_hub: NUM_IRQ must be 1..8");
  end
  if (DATA_W < PRIO_IDX_W + 1 || DATA_W < NUM_IRQ || DATA_W > 32) begin : g_bad_data_w
    $error("io_port_hub: DATA_W too narrow for IRQ registers or wider than 32");
  end
  if (IN_BASE < 0 || OUT_BASE < 0 || IRQ_BASE < 0) begin : g_bad_base
    $error("io_port_hub: base port IDs must be non-negative");
  end

  function automatic logic [DATA_W-1:0] id_at(input int base, input int ofs);
    return DATA_W'(base + ofs);
  endfunction

  logic [NUM_OUT-1:0]    out_hit;
  logic                  mask_wr;
  logic [NUM_IRQ-1:0]    pend_clr;
  logic [NUM_IRQ-1:0]    pend;
  logic [NUM_IRQ-1:0]    mask;
  logic [NUM_IRQ-1:0]    active;
  logic                  prio_vld;
  logic [PRIO_IDX_W-1:0] prio_idx;

  always_comb begin
    out_hit = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      out_hit[j] = IO_STRB && (PORT_ID == id_at(OUT_BASE, j));
    end
  end

  assign mask_wr  = IO_STRB && (PORT_ID == id_at(IRQ_BASE, IRQ_OFS_MASK));
  assign pend_clr = {NUM_IRQ{IO_STRB && (PORT_ID == id_at(IRQ_BASE, IRQ_OFS_PEND))}}
                    & OUT_PORT[NUM_IRQ-1:0];

  for (genvar k = 0; k < NUM_IRQ; k++) begin : g_irq
    irq_edge_latch u_latch (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .src     (IRQ_SRC[k]),
      .clr     (pend_clr[k]),
      .pend    (pend[k])
    );
  end

  // lowest index wins
  always_comb begin
    active   = pend & mask;
    prio_vld = |active;
    prio_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) prio_idx = PRIO_IDX_W'(i);
    end
  end

  always_comb begin
    IN_PORT = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (PORT_ID == id_at(IN_BASE, i)) IN_PORT = IN_DATA[i*DATA_W +: DATA_W];
    end
    if (PORT_ID == id_at(IRQ_BASE, IRQ_OFS_MASK)) begin
      IN_PORT[NUM_IRQ-1:0] = mask;
    end else if (PORT_ID == id_at(IRQ_BASE, IRQ_OFS_PEND)) begin
      IN_PORT[NUM_IRQ-1:0] = pend;
    end else if (PORT_ID == id_at(IRQ_BASE, IRQ_OFS_PRIO)) begin
      IN_PORT[DATA_W-1]       = prio_vld;
      IN_PORT[PRIO_IDX_W-1:0] = prio_idx;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      OUT_DATA  <= '0;
      OUT_WSTB  <= '0;
      mask      <= '0;
      INTERRUPT <= 1'b0;
    end else begin
      OUT_WSTB <= out_hit;
      for (int j = 0; j < NUM_OUT; j++) begin
        if (out_hit[j]) OUT_DATA[j*DATA_W +: DATA_W] <= OUT_PORT;
      end
      if (mask_wr) mask <= OUT_PORT[NUM_IRQ-1:0];
      INTERRUPT <= |active;
    end
  end

endmodule

// File: tb/tb_io_port_hub.sv
// Directed bench for io_port_hub: expected values are queued as stimulus is driven and
// compared when the DUT output is sampled, one cycle step at a time.
module tb_io_port_hub;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [7:0]  PORT_ID;
  logic [7:0]  OUT_PORT;
  logic        IO_STRB;
  logic [31:0] IN_DATA;
  logic [3:0]  IRQ_SRC;
  logic [7:0]  IN_PORT;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_WSTB;
  logic        INTERRUPT;

  io_port_hub #(
    .DATA_W(8), .NUM_IN(4), .NUM_OUT(4), .NUM_IRQ(4),
    .IN_BASE('h20), .OUT_BASE('h40), .IRQ_BASE('hF0)
  ) dut (
    .CLK       (CLK),
    .RESET_N   (RESET_N),
    .PORT_ID   (PORT_ID),
    .OUT_PORT  (OUT_PORT),
    .IO_STRB   (IO_STRB),
    .IN_DATA   (IN_DATA),
    .IRQ_SRC   (IRQ_SRC),
    .IN_PORT   (IN_PORT),
    .OUT_DATA  (OUT_DATA),
    .OUT_WSTB  (OUT_WSTB),
    .INTERRUPT (INTERRUPT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t        sb[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_out   = '0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    vectors++;
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // land 1 time unit after the next rising edge(s)
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // combinational read: at most three of these per clock period
  task automatic rchk(input string tag, input logic [7:0] id, input logic [7:0] exp_v);
    PORT_ID = id;
    push(tag, {24'h0, exp_v});
    #1;
    pop_check({24'h0, IN_PORT});
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    push(tag, exp_v);
    pop_check(obs);
  endtask

  // one strobed write; output registers and write pulses follow from the bench model
  task automatic wr(input logic [7:0] id, input logic [7:0] data);
    logic [3:0] stb;
    stb = 4'b0000;
    if (id >= 8'h40 && id <= 8'h43) begin
      stb[id[1:0]] = 1'b1;
      model_out[id[1:0]*8 +: 8] = data;
    end
    push("wr_out_data", model_out);
    push("wr_out_wstb", {28'h0, stb});
    PORT_ID  = id;
    OUT_PORT = data;
    IO_STRB  = 1'b1;
    step(1);
    IO_STRB  = 1'b0;
    pop_check(OUT_DATA);
    pop_check({28'h0, OUT_WSTB});
  endtask

  initial begin
    RESET_N  = 1'b0;
    PORT_ID  = 8'h00;
    OUT_PORT = 8'h00;
    IO_STRB  = 1'b0;
    IN_DATA  = 32'h0;
    IRQ_SRC  = 4'h0;
    step(2);

    chk("rst_out_data", OUT_DATA, 32'h0);
    chk("rst_wstb", {28'h0, OUT_WSTB}, 32'h0);
    chk("rst_irq", {31'h0, INTERRUPT}, 32'h0);
    rchk("rst_mask", 8'hF0, 8'h00);
    rchk("rst_pend", 8'hF1, 8'h00);
    RESET_N = 1'b1;
    step(4);

    // output register writes and one-cycle strobes
    wr(8'h40, 8'h11);
    wr(8'h41, 8'hA5);
    step(1);
    chk("wstb_drop", {28'h0, OUT_WSTB}, 32'h0);
    chk("out_hold", OUT_DATA, 32'h0000_A511);
    wr(8'h43, 8'h7E);
    wr(8'h23, 8'hEE);
    wr(8'h50, 8'hEE);
    wr(8'hF2, 8'hEE);

    // read mux
    IN_DATA = 32'h3C77_5512;
    rchk("rd_in3", 8'h23, 8'h3C);
    rchk("rd_in0", 8'h20, 8'h12);
    rchk("rd_unmapped", 8'h50, 8'h00);
    step(1);
    rchk("rd_in_range_end", 8'h24, 8'h00);
    rchk("rd_out_id", 8'h41, 8'h00);
    rchk("rd_in1", 8'h21, 8'h55);

    // masked interrupt on source 2
    wr(8'hF0, 8'h0F);
    rchk("mask_rd", 8'hF0, 8'h0F);
    IRQ_SRC = 4'b0100;
    step(2);
    rchk("pend_lat2", 8'hF1, 8'h00);
    IRQ_SRC = 4'b0000;
    step(1);
    rchk("pend_lat3", 8'hF1, 8'h04);
    chk("irq_not_yet", {31'h0, INTERRUPT}, 32'h0);
    step(1);
    chk("irq_set", {31'h0, INTERRUPT}, 32'h1);
    rchk("prio_2", 8'hF2, 8'h82);
    wr(8'hF1, 8'h04);
    rchk("pend_w1c", 8'hF1, 8'h00);
    step(1);
    chk("irq_clear", {31'h0, INTERRUPT}, 32'h0);
    rchk("prio_none", 8'hF2, 8'h00);

    // held source fires once, re-arms on low-then-high, priority picks lowest index
    IRQ_SRC = 4'b0010;
    step(3);
    rchk("hold_pend", 8'hF1, 8'h02);
    wr(8'hF1, 8'h02);
    step(5);
    rchk("hold_no_refire", 8'hF1, 8'h00);
    IRQ_SRC = 4'b0000;
    step(3);
    IRQ_SRC = 4'b1010;
    step(3);
    rchk("rearm_pend", 8'hF1, 8'h0A);
    rchk("prio_1", 8'hF2, 8'h81);
    IRQ_SRC = 4'b0000;
    wr(8'hF1, 8'h02);
    rchk("prio_3", 8'hF2, 8'h83);
    wr(8'hF1, 8'h0F);
    step(2);
    chk("irq_idle", {31'h0, INTERRUPT}, 32'h0);

    // pending latches while masked; unmasking raises the interrupt a cycle later
    wr(8'hF0, 8'h00);
    IRQ_SRC = 4'b0001;
    step(3);
    IRQ_SRC = 4'b0000;
    rchk("masked_pend", 8'hF1, 8'h01);
    step(1);
    chk("masked_no_irq", {31'h0, INTERRUPT}, 32'h0);
    rchk("masked_prio", 8'hF2, 8'h00);
    wr(8'hF0, 8'h01);
    chk("unmask_irq_lag", {31'h0, INTERRUPT}, 32'h0);
    step(1);
    chk("unmask_irq", {31'h0, INTERRUPT}, 32'h1);
    wr(8'hF2, 8'hFF);
    rchk("prio_wr_ignored_mask", 8'hF0, 8'h01);
    rchk("prio_wr_ignored_pend", 8'hF1, 8'h01);

    // clear colliding with a new edge on the same bit: set wins
    IRQ_SRC = 4'b0100;
    step(2);
    wr(8'hF1, 8'h04);
    IRQ_SRC = 4'b0000;
    rchk("w1c_vs_set", 8'hF1, 8'h05);
    wr(8'hF1, 8'h01);
    rchk("w1c_other_bit", 8'hF1, 8'h04);

    // asynchronous reset in the middle of a write, sources held high
    wr(8'hF0, 8'h0F);
    step(1);
    chk("pre_rst_irq", {31'h0, INTERRUPT}, 32'h1);
    IRQ_SRC  = 4'hF;
    PORT_ID  = 8'h40;
    OUT_PORT = 8'hFF;
    IO_STRB  = 1'b1;
    #1;
    RESET_N   = 1'b0;
    model_out = '0;
    #1;
    chk("arst_out_data", OUT_DATA, 32'h0);
    chk("arst_wstb", {28'h0, OUT_WSTB}, 32'h0);
    chk("arst_irq", {31'h0, INTERRUPT}, 32'h0);
    step(1);
    chk("arst_write_discarded", OUT_DATA, 32'h0);
    IO_STRB = 1'b0;
    RESET_N = 1'b1;
    step(6);
    rchk("post_rst_pend", 8'hF1, 8'h00);
    rchk("post_rst_mask", 8'hF0, 8'h00);
    chk("post_rst_irq", {31'h0, INTERRUPT}, 32'h0);
    IRQ_SRC = 4'h0;
    step(3);
    IRQ_SRC = 4'h8;
    step(3);
    rchk("post_rst_rearm", 8'hF1, 8'h08);
    chk("post_rst_out", OUT_DATA, 32'h0);

    if (sb.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_port_hub.md
IO_PORT_HUB -- requirements
Module: io_port_hub

Interface
REQ-001 Parameter DATA_W, default 8, width of the port ID and data buses.
REQ-002 Parameter NUM_IN, default 4, number of readable input ports (1..16).
REQ-003 Parameter NUM_OUT, default 4, number of writable output registers (1..16).
REQ-004 Parameter NUM_IRQ, default 4, number of interrupt sources (1..8).
REQ-005 Parameters IN_BASE/OUT_BASE/IRQ_BASE, defaults 8'h20/8'h40/8'hF0, base port IDs.
REQ-006 CLK  in  1  system clock; all state updates on rising edge.
REQ-007 RESET_N  in  1  asynchronous, active-low reset.
REQ-008 PORT_ID  in  DATA_W  MCU port address.
REQ-009 OUT_PORT  in  DATA_W  MCU write data.
REQ-010 IO_STRB  in  1  MCU write strobe, one cycle per write.
REQ-011 IN_DATA  in  NUM_IN*DATA_W  packed input ports; port i in slice i.
REQ-012 IRQ_SRC  in  NUM_IRQ  asynchronous interrupt request lines.
REQ-013 IN_PORT  out  DATA_W  read data to MCU.
REQ-014 OUT_DATA  out  NUM_OUT*DATA_W  packed output registers.
REQ-015 OUT_WSTB  out  NUM_OUT  one-cycle pulse per written output register.
REQ-016 INTERRUPT  out  1  registered interrupt request to MCU.

Function
REQ-017 Read decode SHALL be combinational: PORT_ID=IN_BASE+i returns IN_DATA slice i; IRQ_BASE+0 mask; +1 pending (zero-extended); +2 {valid, index} of highest-priority active source; any other ID returns 0.
REQ-018 IO_STRB=1 with PORT_ID=OUT_BASE+j SHALL load OUT_PORT into output j on that edge, visible next cycle.
REQ-019 OUT_WSTB[j] SHALL be high for exactly the cycle after the write to output j.
REQ-020 IO_STRB to IRQ_BASE+0 SHALL load the mask register (low NUM_IRQ bits).
REQ-021 IO_STRB to IRQ_BASE+1 SHALL clear pending bits where OUT_PORT bit=1 (write-1-to-clear).
REQ-022 Writes to unmapped IDs, input IDs, and IRQ_BASE+2 SHALL have no effect.
REQ-023 Each IRQ_SRC bit SHALL pass a 2-flop synchroniser, then a rising-edge detector (third flop).
REQ-024 A detected rising edge SHALL set the pending bit; edge-to-pending latency 3 cycles.
REQ-025 Simultaneous edge-set and W1C-clear on the same bit SHALL leave the bit set.
REQ-026 Pending bits SHALL latch regardless of mask; masking gates only INTERRUPT.
REQ-027 INTERRUPT SHALL be registered |(pending & mask), one cycle after the term changes.
REQ-028 Priority SHALL be lowest index highest; index field is 0 with valid=0 when no masked pending bit.
REQ-029 Held-high IRQ_SRC SHALL produce one pending set only; re-arm requires a low-then-high transition.
REQ-030 Out-of-range parameter values SHALL be rejected at elaboration.

Reset
REQ-031 RESET_N low SHALL asynchronously clear all output registers, OUT_WSTB, mask, pending, synchroniser/edge flops and INTERRUPT to 0.
REQ-032 Reset mid-write SHALL discard the write; a source already high at reset release SHALL not set pending.
REQ-033 Deassertion is synchronised externally; no internal reset synchroniser.

Structure
REQ-034 Package io_hub_pkg SHALL hold IRQ register offset constants (MASK=0, PEND=1, PRIO=2) and default base IDs.
REQ-035 One sub-module, irq_edge_latch, SHALL implement per-source synchroniser, edge detect and pending bit; instantiated NUM_IRQ times.

Verification
REQ-036 Write 8'hA5 to ID 8'h41 -> OUT_DATA slice 1 = 8'hA5 next cycle, OUT_WSTB=4'b0010 for one cycle, other slices unchanged.
REQ-037 IN_DATA slice 3 = 8'h3C, PORT_ID=8'h23 -> IN_PORT=8'h3C same cycle; PORT_ID=8'h50 -> 8'h00.
REQ-038 Mask 8'h0F, pulse IRQ_SRC[2] -> pending=8'h04 after 3 cycles, INTERRUPT=1 one cycle later, PRIO read=8'h82.
REQ-039 Mask 8'h00, pulse IRQ_SRC[0] -> pending=8'h01, INTERRUPT stays 0; then write mask 8'h01 -> INTERRUPT=1 one cycle later.
REQ-040 W1C 8'h04 on the cycle IRQ_SRC[2] edge sets -> pending bit 2 remains 1.
REQ-041 RESET_N low during IO_STRB to 8'h40 with IRQ_SRC=4'hF held -> all outputs 0, and after release pending stays 8'h00.
